// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Walks one shared MAC datapath through a full N x N by N x N matrix multiply
// C = A x B. For every (i, j, k) triple, k innermost, it issues one operand
// read (A[i*N+k], B[k*N+j]) per cycle with no bubbles. Delay lines carry the
// valid / first-term / last-term / result-address tags alongside the memory
// and MAC latencies, so the MAC strobes and the result write line up with the
// data arriving from the datapath.
//
// Ports
//   clk              rising-edge system clock
//   rst              synchronous, active-low reset
//   START_CONTROLLER level start request, only looked at while idle
//   busy             high while a multiply is in progress
//   DONE             one-cycle completion pulse (last busy cycle)
//   rd_en            operand memory read enable
//   a_addr           A read address  i*N+k
//   b_addr           B read address  k*N+j
//   mac_en           MAC enable, rd_en delayed by RD_LAT
//   mac_clr          with mac_en: load the product (k==0 term)
//   res_we           result write strobe, one per C element
//   res_addr         C write address i*N+j, zero when res_we is low
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int N       = 10,
  parameter int AW      = 7,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          START_CONTROLLER,
  output logic          busy,
  output logic          DONE,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          res_we,
  output logic [AW-1:0] res_addr
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PL = RD_LAT + MAC_LAT;
  localparam int DW = $clog2(PL + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(PL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [CW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  // Issue-stage tags, already gated by rd_en so the delay lines only ever
  // carry ones for real triples.
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic [AW-1:0] waddr_q, waddr_d;

  logic          last_triple;

  // Row-major linear address r*N+c, truncated to the address width.
  function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c);
    logic [31:0] t;
    t = 32'(r) * 32'(N) + 32'(c);
    return t[AW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    drain_d     = drain_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    a_addr_d    = '0;
    b_addr_d    = '0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    waddr_d     = '0;
    last_triple = (i_q == LAST_IDX) && (j_q == LAST_IDX) && (k_q == LAST_IDX);

    case (state_q)
      S_IDLE: begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        drain_d = '0;
        if (START_CONTROLLER) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy_d   = 1'b1;
        rd_en_d  = 1'b1;
        a_addr_d = lin_addr(i_q, k_q);
        b_addr_d = lin_addr(k_q, j_q);
        first_d  = (k_q == '0);
        last_d   = (k_q == LAST_IDX);
        if (k_q == LAST_IDX) begin
          waddr_d = lin_addr(i_q, j_q);
        end

        // k innermost, then j, then i; every wrap is an explicit compare.
        if (k_q == LAST_IDX) begin
          k_d = '0;
          if (j_q == LAST_IDX) begin
            j_d = '0;
            if (i_q == LAST_IDX) begin
              i_d = '0;
            end else begin
              i_d = i_q + CW'(1);
            end
          end else begin
            j_d = j_q + CW'(1);
          end
        end else begin
          k_d = k_q + CW'(1);
        end

        if (last_triple) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end

      S_DRAIN: begin
        // Stay until the final result write has left the delay line; the
        // exit edge is also the one that raises DONE.
        busy_d = 1'b1;
        if (drain_q == DRAIN_END) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      first_q  <= first_d;
      last_q   <= last_d;
      waddr_q  <= waddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // MAC-side delay line: valid/first tags delayed by the memory read latency.
  // ---------------------------------------------------------------------------
  logic mac_v_q [1:RD_LAT];
  logic mac_f_q [1:RD_LAT];

  genvar gi;
  generate
    for (gi = 1; gi <= RD_LAT; gi++) begin : g_mac_dl
      if (gi == 1) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) begin
            mac_v_q[gi] <= 1'b0;
            mac_f_q[gi] <= 1'b0;
          end else begin
            mac_v_q[gi] <= rd_en_q;
            mac_f_q[gi] <= first_q;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst) begin
            mac_v_q[gi] <= 1'b0;
            mac_f_q[gi] <= 1'b0;
          end else begin
            mac_v_q[gi] <= mac_v_q[gi-1];
            mac_f_q[gi] <= mac_f_q[gi-1];
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Result-side delay line: last-term tag and C address delayed by the read
  // latency plus the MAC latency, so res_we lands when the sum is complete.
  // ---------------------------------------------------------------------------
  logic          res_l_q [1:PL];
  logic [AW-1:0] res_a_q [1:PL];

  generate
    for (gi = 1; gi <= PL; gi++) begin : g_res_dl
      if (gi == 1) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) begin
            res_l_q[gi] <= 1'b0;
            res_a_q[gi] <= '0;
          end else begin
            res_l_q[gi] <= last_q;
            res_a_q[gi] <= waddr_q;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst) begin
            res_l_q[gi] <= 1'b0;
            res_a_q[gi] <= '0;
          end else begin
            res_l_q[gi] <= res_l_q[gi-1];
            res_a_q[gi] <= res_a_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign busy     = busy_q;
  assign DONE     = done_q;
  assign rd_en    = rd_en_q;
  assign a_addr   = a_addr_q;
  assign b_addr   = b_addr_q;
  assign mac_en   = mac_v_q[RD_LAT];
  assign mac_clr  = mac_f_q[RD_LAT];
  assign res_we   = res_l_q[PL];
  assign res_addr = res_a_q[PL];

endmodule
